// File: rtl/adc_sch_arbiter.sv
// Round-robin ADC conversion scheduler: arbitrate, settle the mux, start, collect result, ack.
// Define ADC_SCH_TIMEOUT_EN to abort conversions that see no adc_done within TMO_CYC cycles.
module adc_sch_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CHW     = 4,
    parameter int DW      = 10,
    parameter int TMO_CYC = 255
) (
    input  logic                   clk_adc_sch_12m,
    input  logic                   adc_reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*CHW-1:0] req_chan,
    input  logic [7:0]             settle_cycles,
    output logic [CHW-1:0]         adc_chan_sel,
    output logic                   adc_start,
    input  logic                   adc_done,
    input  logic [DW-1:0]          adc_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [DW-1:0]          result_data,
    output logic                   result_err,
    output logic                   busy,
    output logic                   ungate_req
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TMO_CYC < 1) begin : g_param_chk
        $error("adc_sch_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, SETTLE, START, CONV, RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, grant, arb_idx;
    logic            arb_vld;
    logic [7:0]      settle_cnt;
    logic            conv_tmo;

    // First pending requester at or after ptr; the descending scan lets the lowest offset win.
    always_comb begin : p_arb
        int            pos;
        logic [IW-1:0] pos_i;
        arb_vld = 1'b0;
        arb_idx = '0;
        pos     = 0;
        pos_i   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            pos_i = IW'(pos);
            if (req[pos_i]) begin
                arb_vld = 1'b1;
                arb_idx = pos_i;
            end
        end
    end

    always_ff @(posedge clk_adc_sch_12m or negedge adc_reset_n) begin
        if (!adc_reset_n) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_vld) state_nxt = (settle_cycles != 8'd0) ? SETTLE : START;
            SETTLE:  if (settle_cnt <= 8'd1) state_nxt = START;
            START:   state_nxt = CONV;
            CONV:    if (adc_done || conv_tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        adc_start  = (state == START);
        ack        = '0;
        if (state == RESP) ack[grant] = 1'b1;
        ungate_req = busy | (|req);
    end

    always_ff @(posedge clk_adc_sch_12m or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            ptr          <= '0;
            grant        <= '0;
            adc_chan_sel <= '0;
            settle_cnt   <= '0;
            result_data  <= '0;
        end else begin
            case (state)
                IDLE: if (arb_vld) begin
                    grant        <= arb_idx;
                    adc_chan_sel <= req_chan[arb_idx*CHW +: CHW];
                    settle_cnt   <= settle_cycles;
                end
                SETTLE: settle_cnt <= settle_cnt - 8'd1;
                CONV: begin
                    if (adc_done)      result_data <= adc_data;
                    else if (conv_tmo) result_data <= '0;
                end
                RESP: ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef ADC_SCH_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] tmo_cnt;

    // Counter is zeroed while in START so it reads 0 on the first CONV cycle.
    assign conv_tmo = (state == CONV) && (tmo_cnt == TW'(TMO_CYC - 1));

    always_ff @(posedge clk_adc_sch_12m or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            tmo_cnt    <= '0;
            result_err <= 1'b0;
        end else begin
            if (state == START)     tmo_cnt <= '0;
            else if (state == CONV) tmo_cnt <= tmo_cnt + 1'b1;
            if (state == CONV) begin
                if (adc_done)      result_err <= 1'b0;
                else if (conv_tmo) result_err <= 1'b1;
            end
        end
    end
`else
    assign conv_tmo   = 1'b0;
    assign result_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sch_arbiter.sv
// Directed bench for adc_sch_arbiter: grant/settle timing, fairness, gating, reset, timeout.
module tb_adc_sch_arbiter;

    localparam int NR  = 3;
    localparam int CHW = 4;
    localparam int DW  = 10;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*CHW-1:0] req_chan;
    logic [7:0]        settle_cycles;
    logic [CHW-1:0]    adc_chan_sel;
    logic              adc_start;
    logic              adc_done;
    logic [DW-1:0]     adc_data;
    logic [NR-1:0]     ack;
    logic [DW-1:0]     result_data;
    logic              result_err;
    logic              busy;
    logic              ungate_req;

    int n_assert = 0;
    int n_fail   = 0;

    adc_sch_arbiter #(.NUM_REQ(NR), .CHW(CHW), .DW(DW), .TMO_CYC(16)) dut (
        .clk_adc_sch_12m (clk),
        .adc_reset_n     (rst_n),
        .req             (req),
        .req_chan        (req_chan),
        .settle_cycles   (settle_cycles),
        .adc_chan_sel    (adc_chan_sel),
        .adc_start       (adc_start),
        .adc_done        (adc_done),
        .adc_data        (adc_data),
        .ack             (ack),
        .result_data     (result_data),
        .result_err      (result_err),
        .busy            (busy),
        .ungate_req      (ungate_req)
    );

    initial begin
        clk = 1'b0;
        forever #40 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_chan"},   32'(adc_chan_sel), 32'h0);
        chk({tag, "_start"},  32'(adc_start),    32'h0);
        chk({tag, "_ack"},    32'(ack),          32'h0);
        chk({tag, "_data"},   32'(result_data),  32'h0);
        chk({tag, "_err"},    32'(result_err),   32'h0);
        chk({tag, "_busy"},   32'(busy),         32'h0);
        chk({tag, "_ungate"}, 32'(ungate_req),   32'h0);
    endtask

    logic [NR-1:0]  fair_ack  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [CHW-1:0] fair_chan [4] = '{4'hA, 4'hB, 4'hC, 4'hA};

    initial begin
        rst_n         = 1'b0;
        req           = '0;
        req_chan      = '0;
        settle_cycles = 8'd0;
        adc_done      = 1'b0;
        adc_data      = '0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single request with a 3-cycle settle
        req           = 3'b001;
        req_chan      = 12'h005;
        settle_cycles = 8'd3;
        #1;
        chk("gate_same_cycle", 32'(ungate_req), 32'h1);
        chk("idle_busy",       32'(busy),       32'h0);
        tick();
        chk("s1_chan",        32'(adc_chan_sel), 32'h5);
        chk("s1_settle_busy", 32'(busy),         32'h1);
        chk("s1_settle_start",32'(adc_start),    32'h0);
        tick();
        tick();
        chk("s1_start_early", 32'(adc_start), 32'h0);
        tick();
        chk("s1_start",       32'(adc_start), 32'h1);
        tick();
        chk("s1_start_1cyc",  32'(adc_start), 32'h0);
        repeat (9) tick();
        chk("s1_no_ack_yet",  32'(ack), 32'h0);
        adc_done = 1'b1;
        adc_data = 10'h2A5;
        tick();
        adc_done = 1'b0;
        adc_data = '0;
        chk("s1_ack",    32'(ack),         32'h1);
        chk("s1_data",   32'(result_data), 32'h2A5);
        chk("s1_err",    32'(result_err),  32'h0);
        chk("s1_gate_ack", 32'(ungate_req), 32'h1);
        req = '0;
        tick();
        chk("s1_busy_after",  32'(busy),        32'h0);
        chk("s1_ack_1cyc",    32'(ack),         32'h0);
        chk("s1_data_hold",   32'(result_data), 32'h2A5);
        chk("s1_gate_off",    32'(ungate_req),  32'h0);

        // Zero settle, early done in START is ignored, req_chan change after grant ignored
        settle_cycles = 8'd0;
        req           = 3'b010;
        req_chan      = 12'h070;
        tick();
        chk("z_start",  32'(adc_start),    32'h1);
        chk("z_chan",   32'(adc_chan_sel), 32'h7);
        adc_done = 1'b1;
        adc_data = 10'h3FF;
        tick();
        adc_done = 1'b0;
        adc_data = '0;
        req_chan = 12'h0E0;
        chk("z_conv_busy", 32'(busy), 32'h1);
        chk("z_early_ack", 32'(ack),  32'h0);
        tick();
        chk("z_still_conv", 32'(ack),          32'h0);
        chk("z_chan_hold",  32'(adc_chan_sel), 32'h7);
        adc_done = 1'b1;
        adc_data = 10'h155;
        tick();
        adc_done = 1'b0;
        adc_data = '0;
        chk("z_ack",  32'(ack),         32'h2);
        chk("z_data", 32'(result_data), 32'h155);
        req = '0;
        tick();
        chk("z_idle", 32'(busy), 32'h0);

        // Reset in the middle of a conversion
        req      = 3'b100;
        req_chan = 12'h900;
        tick();
        tick();
        tick();
        chk("r_conv_busy", 32'(busy), 32'h1);
        #10;
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk_idle_outputs("r_async");
        tick();
        chk("r_no_ack", 32'(ack), 32'h0);
        rst_n = 1'b1;
        req   = 3'b100;
        tick();
        chk("r_regrant_start", 32'(adc_start),    32'h1);
        chk("r_regrant_chan",  32'(adc_chan_sel), 32'h9);
        tick();
        adc_done = 1'b1;
        adc_data = 10'h0AA;
        tick();
        adc_done = 1'b0;
        adc_data = '0;
        chk("r_ack",  32'(ack),         32'h4);
        chk("r_data", 32'(result_data), 32'h0AA);
        req = '0;
        tick();

        // Fairness: all three held, minimum-latency conversions
        req      = 3'b111;
        req_chan = 12'hCBA;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("f%0d_start", i), 32'(adc_start),    32'h1);
            chk($sformatf("f%0d_chan", i),  32'(adc_chan_sel), 32'(fair_chan[i]));
            tick();
            adc_done = 1'b1;
            adc_data = DW'(10'h100 + i);
            tick();
            adc_done = 1'b0;
            adc_data = '0;
            chk($sformatf("f%0d_ack", i),  32'(ack),         32'(fair_ack[i]));
            chk($sformatf("f%0d_data", i), 32'(result_data), 32'h100 + 32'(i));
            tick();
            chk($sformatf("f%0d_idle", i), 32'(busy),       32'h0);
            chk($sformatf("f%0d_gate", i), 32'(ungate_req), 32'h1);
        end
        req = '0;
        #1;
        chk("f_gate_off", 32'(ungate_req), 32'h0);

        // Conversion with no adc_done
        req = 3'b001;
        tick();
        tick();
`ifdef ADC_SCH_TIMEOUT_EN
        repeat (15) tick();
        chk("t_no_ack_early", 32'(ack), 32'h0);
        tick();
        chk("t_ack",  32'(ack),         32'h1);
        chk("t_err",  32'(result_err),  32'h1);
        chk("t_data", 32'(result_data), 32'h0);
        req = '0;
        tick();
        chk("t_idle", 32'(busy), 32'h0);
`else
        repeat (40) tick();
        chk("t_stuck_busy", 32'(busy), 32'h1);
        chk("t_stuck_ack",  32'(ack),  32'h0);
        chk("t_err_zero",   32'(result_err), 32'h0);
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sch_arbiter.md
Name: adc_sch_arbiter

Overview:
- Conversion scheduler for the shared ADC scheduler datapath. Runs in the clk_adc_sch_12m domain.
- Arbitrates conversion requests round-robin from NUM_REQ functional requesters, such as adc_monx_cfg, clear_px_average and vbus_discharge_en.
- Sequences each granted request through mux settle, conversion start, and result return.
- Drives an ungate request to the HF clock gating logic so the 12.5 MHz clock stays enabled while work is pending or in flight.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- CHW, 4, ADC channel select width.
- DW, 10, ADC result width.
- TMO_CYC, 255, conversion timeout in cycles (used only with the optional feature).

Ports:
- clk_adc_sch_12m  input  1  scheduler clock, 12.5 MHz.
- adc_reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester level request; held until matching ack.
- req_chan  input  NUM_REQ*CHW  channel per requester; requester i uses bits [i*CHW +: CHW].
- settle_cycles  input  8  mux settle time in cycles; 0 means no settle.
- adc_chan_sel  output  CHW  channel driven to the ADC mux.
- adc_start  output  1  one-cycle conversion start pulse.
- adc_done  input  1  one-cycle conversion complete pulse.
- adc_data  input  DW  result, valid while adc_done = 1.
- ack  output  NUM_REQ  one-hot, one-cycle completion to the granted requester.
- result_data  output  DW  registered result, valid with ack.
- result_err  output  1  set with ack when the conversion timed out.
- busy  output  1  high in any state other than IDLE.
- ungate_req  output  1  high when busy is high or when any req bit is high.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer = 0, settle counter = 0, timeout counter = 0. Reset is asynchronous and active-low; the clock is clk_adc_sch_12m.
- FSM states: IDLE, SETTLE, START, CONV, RESP.
- IDLE:
  - If any req bit is high, grant the first requester at or after the pointer, in increasing index order with wrap.
  - Latch the grant index and its req_chan into adc_chan_sel.
  - Next state is SETTLE if settle_cycles != 0, otherwise START.
- SETTLE:
  - Load settle_cycles on entry and decrement each cycle.
  - Go to START in the cycle the count reaches 1, so the dwell is exactly settle_cycles cycles.
- START: adc_start = 1 for exactly one cycle, then go to CONV.
- CONV:
  - Wait for adc_done, then capture adc_data into result_data and go to RESP.
  - adc_done arriving in the same cycle as adc_start is ignored.
- RESP:
  - ack[grant] = 1 for one cycle.
  - result_data is stable from this cycle until the next RESP.
  - Pointer = grant+1, wrapping at NUM_REQ.
  - Return to IDLE.
- adc_chan_sel holds the granted channel from grant until the next grant; changes to req_chan after grant are ignored.
- Request rules:
  - A requester drops req in the cycle after ack.
  - If req is still high in IDLE, it is a new request, arbitrated behind the others because the pointer has advanced.
  - A req bit dropped before ack does not abort an in-flight sequence; the ack is still issued.
- Minimum back-to-back throughput, with settle_cycles = 0 and adc_done one cycle after start: IDLE→START→CONV→RESP→IDLE, 4 cycles per conversion plus the ADC latency.
- Clock gating: ungate_req is combinational from busy and the OR of req. It must be high in the same cycle a req arrives, so the gated clock is not stopped before the grant.
- Reset mid-operation: any state returns to IDLE immediately. No ack is issued, the pointer returns to 0, and adc_start is deasserted asynchronously.
- An adc_done received outside CONV is ignored.

Optional Feature:
- Macro: ADC_SCH_TIMEOUT_EN.
- Defined:
  - CONV counts cycles.
  - If TMO_CYC cycles pass without adc_done, go to RESP with result_data = 0 and result_err = 1.
  - The counter clears on CONV entry.
- Not defined:
  - CONV waits indefinitely.
  - result_err is tied to 0 and the timeout counter is not synthesized.

Test Plan:
- Single request: reset, then req=3'b001, req_chan[3:0]=4'h5, settle_cycles=3, adc_done 10 cycles after start with data 10'h2A5. Required: adc_chan_sel=5 one cycle after grant, adc_start exactly 3 cycles after SETTLE entry, ack=3'b001 with result_data=10'h2A5, busy low one cycle later.
- Fairness: req=3'b111 held, re-asserted after each ack. Required: ack order 001→010→100→001, each requester served once per three conversions.
- Gating: req rises while idle. Required: ungate_req=1 the same cycle, staying high until the cycle after ack; with req=0 and idle, ungate_req=0.
- Zero settle and early done: settle_cycles=0. Required: START the cycle after grant. An adc_done pulse in the START cycle is ignored and a later adc_done completes the conversion.
- Reset mid-CONV: drop adc_reset_n during CONV. Required: all outputs 0 asynchronously and no ack. After release, req=3'b100 is granted, since pointer=0 finds index 2 first.
- Timeout (ADC_SCH_TIMEOUT_EN, TMO_CYC=16): no adc_done. Required: ack 16 cycles after CONV entry with result_err=1 and result_data=0. Without the macro, busy stays high indefinitely.
